// File: rtl/piso_stream_serializer.sv
// Parallel-to-serial word shifter with start/end strobes; first bit appears one cycle after acceptance.
// One-word holding register keeps words back-to-back; din_ready drops only while that register is full.
module piso_stream_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             dout,
    output logic             dout_valid,
    output logic             serial_start,
    output logic             serial_end,
    output logic             busy
);

    localparam int             CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t             r_state;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_shift;
    logic [WIDTH-1:0]   r_hold;
    logic               r_hold_full;

    state_t             w_state_nxt;
    logic [CW-1:0]      w_cnt_nxt;
    logic [WIDTH-1:0]   w_shift_nxt;
    logic [WIDTH-1:0]   w_hold_nxt;
    logic               w_hold_full_nxt;

    logic               w_shifting;
    logic               w_last;
    logic               w_accept;
    logic [WIDTH-1:0]   w_shifted;

    assign w_shifting = (r_state == ST_SHIFT);
    assign w_last     = w_shifting && (r_cnt == LAST_BIT);
    assign din_ready  = !r_hold_full && !reset;
    assign w_accept   = din_valid && din_ready;

    // Register moves toward whichever end feeds dout.
    assign w_shifted  = MSB_FIRST ? {r_shift[WIDTH-2:0], 1'b0}
                                  : {1'b0, r_shift[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_shift     <= '0;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_shift     <= w_shift_nxt;
            r_hold      <= w_hold_nxt;
            r_hold_full <= w_hold_full_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_shift_nxt     = r_shift;
        w_hold_nxt      = r_hold;
        w_hold_full_nxt = r_hold_full;

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_SHIFT;
                    w_shift_nxt = din;
                    w_cnt_nxt   = '0;
                end
            end
            ST_SHIFT: begin
                w_shift_nxt = w_shifted;
                w_cnt_nxt   = r_cnt + 1'b1;
                if (w_last) begin
                    w_cnt_nxt = '0;
                    // Held word has priority; a full holder also blocks new accepts.
                    if (r_hold_full) begin
                        w_shift_nxt     = r_hold;
                        w_hold_full_nxt = 1'b0;
                    end else if (w_accept) begin
                        w_shift_nxt = din;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else if (w_accept) begin
                    w_hold_nxt      = din;
                    w_hold_full_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign dout         = w_shifting && (MSB_FIRST ? r_shift[WIDTH-1] : r_shift[0]);
    assign dout_valid   = w_shifting;
    assign serial_start = w_shifting && (r_cnt == '0);
    assign serial_end   = w_last;
    assign busy         = w_shifting || r_hold_full;

endmodule

// File: tb/tb_piso_stream_serializer.sv
// Bench for piso_stream_serializer: three instances (8-bit LSB-first, 8-bit MSB-first, 5-bit LSB-first)
// compared every cycle against a word-queue model of the serial stream.
module tb_piso_stream_serializer;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] din_a [3];
    logic        vld_a [3];
    wire  [2:0]  o_rdy, o_dout, o_vld, o_st, o_end, o_bsy;

    int checks = 0;
    int errors = 0;

    // Model: queue of words inside the block (head is on the wire), and bit position of the head.
    int unsigned mq [3][$];
    int          mbi [3];

    always #5 clk = ~clk;

    piso_stream_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb8 (
        .clk(clk), .reset(reset), .din(din_a[0][7:0]), .din_valid(vld_a[0]),
        .din_ready(o_rdy[0]), .dout(o_dout[0]), .dout_valid(o_vld[0]),
        .serial_start(o_st[0]), .serial_end(o_end[0]), .busy(o_bsy[0]));

    piso_stream_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb8 (
        .clk(clk), .reset(reset), .din(din_a[1][7:0]), .din_valid(vld_a[1]),
        .din_ready(o_rdy[1]), .dout(o_dout[1]), .dout_valid(o_vld[1]),
        .serial_start(o_st[1]), .serial_end(o_end[1]), .busy(o_bsy[1]));

    piso_stream_serializer #(.WIDTH(5), .MSB_FIRST(1'b0)) u_lsb5 (
        .clk(clk), .reset(reset), .din(din_a[2][4:0]), .din_valid(vld_a[2]),
        .din_ready(o_rdy[2]), .dout(o_dout[2]), .dout_valid(o_vld[2]),
        .serial_start(o_st[2]), .serial_end(o_end[2]), .busy(o_bsy[2]));

    function automatic int mw(int id);
        return (id == 2) ? 5 : 8;
    endfunction

    function automatic bit msb(int id);
        return (id == 1);
    endfunction

    // {din_ready, dout_valid, dout, serial_start, serial_end, busy}
    function automatic logic [5:0] exp_vec(int id);
        logic [5:0]  v;
        int          idx;
        int unsigned w;
        v    = '0;
        v[5] = !reset && (mq[id].size() < 2);
        if (mq[id].size() > 0) begin
            idx  = msb(id) ? (mw(id) - 1 - mbi[id]) : mbi[id];
            w    = mq[id][0];
            v[4] = 1'b1;
            v[3] = w[idx];
            v[2] = (mbi[id] == 0);
            v[1] = (mbi[id] == mw(id) - 1);
            v[0] = 1'b1;
        end
        return v;
    endfunction

    function automatic logic [5:0] act_vec(int id);
        return {o_rdy[id], o_vld[id], o_dout[id], o_st[id], o_end[id], o_bsy[id]};
    endfunction

    function automatic void model_update();
        bit acc;
        for (int id = 0; id < 3; id++) begin
            if (reset) begin
                mq[id].delete();
                mbi[id] = 0;
            end else begin
                acc = vld_a[id] && (mq[id].size() < 2);
                if (mq[id].size() > 0) begin
                    mbi[id]++;
                    if (mbi[id] == mw(id)) begin
                        void'(mq[id].pop_front());
                        mbi[id] = 0;
                    end
                end
                if (acc) mq[id].push_back(din_a[id] & ((32'd1 << mw(id)) - 32'd1));
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        for (int id = 0; id < 3; id++) begin
            checks++;
            if (act_vec(id) !== 6'b000000) begin
                errors++;
                $display("FAIL reset_hold inst%0d: got %b expected %b", id, act_vec(id), 6'b000000);
            end
        end
        reset = 1'b0;
        #1;
        for (int id = 0; id < 3; id++) begin
            checks++;
            if (act_vec(id) !== 6'b100000 || exp_vec(id) !== 6'b100000) begin
                errors++;
                $display("FAIL reset_release inst%0d: got %b expected %b", id, act_vec(id), 6'b100000);
            end
        end
    endtask

    task automatic test_lsb_a5();
        logic [7:0] coll;
        coll     = '0;
        din_a[0] = 32'hA5;
        vld_a[0] = 1'b1;
        tick();
        vld_a[0] = 1'b0;
        din_a[0] = 32'h5A;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (act_vec(0) !== exp_vec(0)) begin
                errors++;
                $display("FAIL lsb_a5 cycle %0d: got %b expected %b", i, act_vec(0), exp_vec(0));
            end
            checks++;
            if (o_vld[0] !== (i < 8) || o_st[0] !== (i == 0) || o_end[0] !== (i == 7)) begin
                errors++;
                $display("FAIL lsb_a5_frame cycle %0d: vld/st/end %b%b%b", i, o_vld[0], o_st[0], o_end[0]);
            end
            if (i < 8) coll[i] = o_dout[0];
            tick();
        end
        checks++;
        if (coll !== 8'hA5) begin
            errors++;
            $display("FAIL lsb_a5_word: got %h expected a5", coll);
        end
    endtask

    task automatic test_msb_a5();
        logic [7:0] coll;
        coll     = '0;
        din_a[1] = 32'hA5;
        vld_a[1] = 1'b1;
        tick();
        vld_a[1] = 1'b0;
        din_a[1] = 32'h00;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (act_vec(1) !== exp_vec(1)) begin
                errors++;
                $display("FAIL msb_a5 cycle %0d: got %b expected %b", i, act_vec(1), exp_vec(1));
            end
            if (i < 8) coll = {coll[6:0], o_dout[1]};
            tick();
        end
        checks++;
        if (coll !== 8'hA5) begin
            errors++;
            $display("FAIL msb_a5_word: got %h expected a5", coll);
        end
    endtask

    task automatic test_w5();
        logic [4:0] coll;
        coll     = '0;
        din_a[2] = 32'h13;
        vld_a[2] = 1'b1;
        tick();
        vld_a[2] = 1'b0;
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (act_vec(2) !== exp_vec(2)) begin
                errors++;
                $display("FAIL w5 cycle %0d: got %b expected %b", i, act_vec(2), exp_vec(2));
            end
            checks++;
            if (o_end[2] !== (i == 4) || o_vld[2] !== (i < 5)) begin
                errors++;
                $display("FAIL w5_frame cycle %0d: end %b vld %b", i, o_end[2], o_vld[2]);
            end
            if (i < 5) coll[i] = o_dout[2];
            tick();
        end
        checks++;
        if (coll !== 5'b10011) begin
            errors++;
            $display("FAIL w5_word: got %b expected 10011", coll);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] words [3];
        logic [5:0] ev;
        int  idx, run, maxrun, bnd, stall;
        bit  acc;
        logic prev_end;
        words[0] = 8'h01; words[1] = 8'h80; words[2] = 8'hFF;
        idx = 0; run = 0; maxrun = 0; bnd = 0; stall = 0; prev_end = 1'b0;
        for (int c = 0; c < 40; c++) begin
            din_a[0] = (idx < 3) ? {24'h0, words[idx]} : $urandom;
            vld_a[0] = (idx < 3);
            #1;
            ev  = exp_vec(0);
            acc = vld_a[0] && ev[5];
            if (vld_a[0] && o_rdy[0] === 1'b0) stall++;
            tick();
            if (acc) idx++;
            checks++;
            if (act_vec(0) !== exp_vec(0)) begin
                errors++;
                $display("FAIL b2b cycle %0d: got %b expected %b", c, act_vec(0), exp_vec(0));
            end
            if (o_vld[0] === 1'b1) run++;
            else begin
                if (run > maxrun) maxrun = run;
                run = 0;
            end
            if (prev_end === 1'b1 && o_st[0] === 1'b1) bnd++;
            prev_end = o_end[0];
        end
        vld_a[0] = 1'b0;
        checks++;
        if (maxrun != 24) begin
            errors++;
            $display("FAIL b2b_run: got %0d valid bits in a row, expected 24", maxrun);
        end
        checks++;
        if (bnd != 2) begin
            errors++;
            $display("FAIL b2b_boundary: got %0d end->start pairs, expected 2", bnd);
        end
        checks++;
        if (stall != 7) begin
            errors++;
            $display("FAIL b2b_stall: got %0d ready-low cycles, expected 7", stall);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] coll;
        coll     = '0;
        din_a[0] = 32'h3C;
        vld_a[0] = 1'b1;
        tick();
        din_a[0] = 32'h99;
        tick();
        vld_a[0] = 1'b0;
        for (int i = 0; i < 8 && mbi[0] != 3; i++) tick();
        checks++;
        if (act_vec(0) !== exp_vec(0) || o_dout[0] !== 1'b1 || mq[0].size() != 2) begin
            errors++;
            $display("FAIL rst_mid_pre: got %b expected %b (bit3 of 3c = 1)", act_vec(0), exp_vec(0));
        end
        reset    = 1'b1;
        din_a[0] = 32'h77;
        vld_a[0] = 1'b1;
        #1;
        checks++;
        if (o_rdy[0] !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_ready: got %b expected 0", o_rdy[0]);
        end
        tick();
        checks++;
        if (act_vec(0) !== 6'b000000 || exp_vec(0) !== 6'b000000) begin
            errors++;
            $display("FAIL rst_mid_flush: got %b expected 000000", act_vec(0));
        end
        reset    = 1'b0;
        din_a[0] = 32'h55;
        tick();
        vld_a[0] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (act_vec(0) !== exp_vec(0)) begin
                errors++;
                $display("FAIL rst_mid_post cycle %0d: got %b expected %b", i, act_vec(0), exp_vec(0));
            end
            if (i < 8) coll[i] = o_dout[0];
            tick();
        end
        checks++;
        if (coll !== 8'h55) begin
            errors++;
            $display("FAIL rst_mid_word: got %h expected 55", coll);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 900; c++) begin
            for (int id = 0; id < 3; id++) begin
                din_a[id] = $urandom;
                vld_a[id] = ($urandom_range(0, 3) != 0);
            end
            reset = ($urandom_range(0, 120) == 0);
            tick();
            for (int id = 0; id < 3; id++) begin
                checks++;
                if (act_vec(id) !== exp_vec(id)) begin
                    errors++;
                    $display("FAIL random cycle %0d inst%0d: got %b expected %b", c, id, act_vec(id), exp_vec(id));
                end
            end
        end
        reset = 1'b0;
        for (int id = 0; id < 3; id++) vld_a[id] = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            for (int id = 0; id < 3; id++) begin
                checks++;
                if (act_vec(id) !== exp_vec(id)) begin
                    errors++;
                    $display("FAIL drain cycle %0d inst%0d: got %b expected %b", c, id, act_vec(id), exp_vec(id));
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        for (int id = 0; id < 3; id++) begin
            din_a[id] = '0;
            vld_a[id] = 1'b0;
            mbi[id]   = 0;
        end
        test_reset();
        test_lsb_a5();
        test_msb_a5();
        test_w5();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
